// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for the I-cache port, the D-cache port and the shared memory port.
// master = caches + memory (testbench side), slave = the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output i_read, i_write, i_addr, i_wdata,
    input  i_rdata, i_ready,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

  modport slave (
    input  i_read, i_write, i_addr, i_wdata,
    output i_rdata, i_ready,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between I and D caches: D wins unless I has waited STARVE_LIMIT grants.
// Grant visible 1 cycle after sampling, ready 1 cycle after mem_ready; requesters hold their lines while a transaction is in flight.
module mem_port_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q;
  logic [3:0]        starve_cnt_q;
  logic [3:0]        starve_cnt_d;
  logic              owner_d_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_ready_q;
  logic              d_ready_q;

  logic d_req;
  logic i_req;
  logic i_forced;
  logic grant_d;
  logic grant_i;

  assign d_req    = bus.d_read | bus.d_write;
  assign i_req    = bus.i_read | bus.i_write;
  assign i_forced = i_req && (starve_cnt_q == LIMIT);
  assign grant_d  = d_req && !i_forced;
  assign grant_i  = i_req && !grant_d;

  // Counts D grants taken while I was waiting; any other grant clears it.
  always_comb begin
    starve_cnt_d = '0;
    if (grant_d && i_req) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      owner_d_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d || grant_i) begin
            // Read and write together is served as a write.
            mem_write_q  <= grant_d ? bus.d_write : bus.i_write;
            mem_read_q   <= grant_d ? (bus.d_read & ~bus.d_write) : (bus.i_read & ~bus.i_write);
            mem_addr_q   <= grant_d ? bus.d_addr  : bus.i_addr;
            mem_wdata_q  <= grant_d ? bus.d_wdata : bus.i_wdata;
            owner_d_q    <= grant_d;
            starve_cnt_q <= starve_cnt_d;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (mem_read_q) begin
              if (owner_d_q) d_rdata_q <= bus.mem_rdata;
              else           i_rdata_q <= bus.mem_rdata;
            end
            if (owner_d_q) d_ready_q <= 1'b1;
            else           i_ready_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.d_ready   = d_ready_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one slow_memory port (128-bit line, 28-bit line address) between the I-cache and D-cache miss/writeback interfaces.
- Sits between CHIP's two cache refill ports and a single off-chip memory, replacing the dual slow_memory arrangement.
- Fixed D-over-I priority with a starvation guard; one outstanding transaction at a time; registered downstream outputs.

Parameters:
- ADDR_W, 28, line address width (address bits [31:4]).
- DATA_W, 128, line data width.
- STARVE_LIMIT, 4, consecutive D grants allowed while I is pending before I is forced; range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- i_read  in  1  I-side read request.
- i_write  in  1  I-side write request.
- i_addr  in  ADDR_W  I-side line address.
- i_wdata  in  DATA_W  I-side write line.
- i_rdata  out  DATA_W  I-side read line, valid while i_ready=1.
- i_ready  out  1  I-side completion pulse.
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: same as I-side, for D.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_rdata  in  DATA_W  downstream read data, valid with mem_ready.
- mem_ready  in  1  downstream completion.

Behaviour:
- Reset (async, rst=1): state=IDLE, starve_cnt=0. mem_read, mem_write, i_ready, d_ready = 0. mem_addr, mem_wdata, i_rdata, d_rdata = 0.
- Requester protocol: a request (read or write) is held stable until that side's ready pulses, then dropped on the next edge. Read and write asserted together is treated as a write.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Sample d_req=d_read|d_write and i_req=i_read|i_write.
  - Winner is D if d_req and not (i_req and starve_cnt==STARVE_LIMIT); otherwise I if i_req.
  - On a grant: register the winner's op, addr and wdata into the mem_* outputs; latch grant owner; go to BUSY.
  - Downstream request is visible the cycle after sampling (1-cycle grant latency).
- BUSY:
  - Hold mem_* stable until mem_ready=1.
  - On mem_ready: clear mem_read/mem_write; copy mem_rdata to the owner's rdata register (reads only; writes leave rdata unchanged); go to RESP.
- RESP:
  - Owner's ready=1 for exactly one cycle; return to IDLE.
  - The non-owner's ready is never asserted.
- starve_cnt update, on each grant:
  - D granted while i_req=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - I granted: starve_cnt=0.
  - D granted with i_req=0: starve_cnt=0.
- Minimum turnaround: request sample to ready = 3 cycles + memory latency. Back-to-back grants are separated by at least one IDLE cycle.
- Requests arriving while BUSY or RESP wait; nothing is queued beyond the held request lines.
- mem_ready while IDLE or RESP is ignored.
- Request dropped by the owner mid-BUSY: the transaction still completes and ready still pulses (protocol violation; must not hang).
- rst asserted mid-transaction: immediate return to reset values; the transaction is abandoned and no ready is issued.

Test Plan:
- Single I read, i_addr=28'h0000010, memory returns 128'hA5..A5 after 5 cycles -> mem_read=1 with mem_addr=28'h0000010 one cycle after request; i_ready pulses 1 cycle with i_rdata=128'hA5..A5; d_ready stays 0.
- D write, d_addr=28'h0000020, d_wdata=128'h1234 -> mem_write=1 with the same addr/data held until mem_ready; d_ready pulses once; d_rdata unchanged.
- I and D request in the same cycle, STARVE_LIMIT=4 -> D served first, then I.
- D held continuously with I also pending -> exactly 4 D grants, then 1 I grant, then D resumes with starve_cnt=0.
- rst pulsed during BUSY -> all outputs 0 asynchronously, no ready pulse; a fresh request after release completes normally.
- Read+write asserted together on D -> mem_write=1, mem_read=0.
